// File: rtl/uart_rx_param_if.sv
// Client-side port bundle of the UART receiver: show-ahead FIFO read port, status and error flags.
// Latency/backpressure: none of its own; a full FIFO makes the receiver drop words and flag overrun.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rd_en;
    logic                 clr_err;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 fifo_full;
    logic                 rx_busy;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 break_det;
    logic [3:0]           err_status;

    modport master (
        input  rd_en, clr_err,
        output rd_data, rd_valid, fifo_full, rx_busy,
               parity_err, frame_err, overrun_err, break_det, err_status
    );

    modport slave (
        output rd_en, clr_err,
        input  rd_data, rd_valid, fifo_full, rx_busy,
               parity_err, frame_err, overrun_err, break_det, err_status
    );
endinterface

// File: rtl/uart_rx_param.sv
// UART receiver with 3-sample majority vote, parity/stop/break checks and a show-ahead FIFO; word written at stop-bit centre.
// No backpressure on the line: a full FIFO without a same-cycle pop drops the word and raises overrun_err.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            iCLK,
    input  logic            RST_n,
    input  logic            rx,
    uart_rx_param_if.master bus
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int MID = DIV / 2;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s, rx_d;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] data;
    logic                 par_bit, par_fault, stop_low_seen, stop_low_all;
    logic                 samp0, samp1, maj;
    logic                 start_edge, in_frame, decide, last_stop;
    logic                 brk, fe, pe, clean, push, pop, ovr;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 full, not_empty;
    logic                 parity_q, frame_q, overrun_q, break_q;
    logic [3:0]           status_q;

    // Synchroniser resets to idle-high so a reset release never looks like a start edge.
    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign start_edge = (state == S_IDLE) && rx_d && !rx_s;
    assign in_frame   = (state == S_START) || (state == S_DATA) || (state == S_PAR) || (state == S_STOP);
    assign decide     = in_frame && (cnt == CW'(MID + 1));
    assign maj        = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

    assign last_stop  = (state == S_STOP) && decide && (stop_idx == 1'(STOP_BITS - 1));
    assign brk        = last_stop && (data == '0) && !par_bit && stop_low_all && !maj;
    assign fe         = last_stop && (stop_low_seen || !maj) && !brk;
    assign pe         = last_stop && par_fault && !brk;
    assign clean      = last_stop && !stop_low_seen && maj && !par_fault;
    assign pop        = bus.rd_en && not_empty;
    assign push       = clean && (!full || pop);
    assign ovr        = clean && full && !pop;

    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_edge) state_nxt = S_START;
            S_START: if (decide) state_nxt = maj ? S_IDLE : S_DATA;
            S_DATA:  if (decide && (bit_idx == BW'(DATA_BITS - 1)))
                         state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (decide) state_nxt = S_STOP;
            S_STOP:  if (last_stop) state_nxt = brk ? S_BRK : S_IDLE;
            S_BRK:   if (rx_s) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The start-edge cycle counts as cnt 0, so bit k is decided k*DIV+MID+1 cycles later.
    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt           <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            data          <= '0;
            par_bit       <= 1'b0;
            par_fault     <= 1'b0;
            stop_low_seen <= 1'b0;
            stop_low_all  <= 1'b1;
            samp0         <= 1'b1;
            samp1         <= 1'b1;
        end else if (start_edge) begin
            cnt           <= CW'(1);
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            data          <= '0;
            par_bit       <= 1'b0;
            par_fault     <= 1'b0;
            stop_low_seen <= 1'b0;
            stop_low_all  <= 1'b1;
        end else begin
            if (state == S_IDLE)          cnt <= '0;
            else if (cnt == CW'(DIV - 1)) cnt <= '0;
            else                          cnt <= cnt + CW'(1);
            if (cnt == CW'(MID - 1)) samp0 <= rx_s;
            if (cnt == CW'(MID))     samp1 <= rx_s;
            if (decide) begin
                case (state)
                    S_DATA: begin
                        data[bit_idx] <= maj;
                        bit_idx       <= bit_idx + BW'(1);
                    end
                    S_PAR: begin
                        par_bit   <= maj;
                        par_fault <= (^data) ^ maj ^ (PARITY == 1);
                    end
                    S_STOP: begin
                        stop_idx      <= stop_idx + 1'b1;
                        stop_low_seen <= stop_low_seen | !maj;
                        stop_low_all  <= stop_low_all & !maj;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign not_empty = (count != '0);

    always_ff @(posedge iCLK) begin
        if (push) mem[wr_ptr] <= data;
    end

    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // A new error in the same cycle as clr_err survives the clear.
    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            parity_q  <= 1'b0;
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
            break_q   <= 1'b0;
            status_q  <= '0;
        end else begin
            parity_q  <= pe;
            frame_q   <= fe;
            overrun_q <= ovr;
            break_q   <= brk;
            status_q  <= (status_q & ~{4{bus.clr_err}}) | {brk, ovr, fe, pe};
        end
    end

    assign bus.rd_data     = not_empty ? mem[rd_ptr] : '0;
    assign bus.rd_valid    = not_empty;
    assign bus.fifo_full   = full;
    assign bus.rx_busy     = (state != S_IDLE);
    assign bus.parity_err  = parity_q;
    assign bus.frame_err   = frame_q;
    assign bus.overrun_err = overrun_q;
    assign bus.break_det   = break_q;
    assign bus.err_status  = status_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench: one receiver at default rates (latency, 8N1) and one fast 8E1 receiver for error, FIFO and random traffic.
module tb_uart_rx_param;
    localparam int A_DIV  = 50_000_000 / 115200;
    localparam int A_MID  = A_DIV / 2;
    localparam int B_CLK  = 1_600_000;
    localparam int B_BAUD = 100_000;
    localparam int B_DIV  = B_CLK / B_BAUD;
    localparam int B_MID  = B_DIV / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rx_a, rx_b;
    uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_param_if #(.DATA_BITS(8)) bus_b ();

    uart_rx_param dut_a (.iCLK(clk), .RST_n(rst_n), .rx(rx_a), .bus(bus_a));
    uart_rx_param #(.CLK_FREQ(B_CLK), .BAUD(B_BAUD), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (.iCLK(clk), .RST_n(rst_n), .rx(rx_b), .bus(bus_b));

    int checks = 0, errors = 0;
    int a_err_n = 0, b_pe = 0, b_fe = 0, b_oe = 0, b_bk = 0;

    always @(negedge clk) begin
        if (bus_a.parity_err || bus_a.frame_err || bus_a.overrun_err || bus_a.break_det) a_err_n++;
        if (bus_b.parity_err)  b_pe++;
        if (bus_b.frame_err)   b_fe++;
        if (bus_b.overrun_err) b_oe++;
        if (bus_b.break_det)   b_bk++;
    end

    typedef struct {
        logic [7:0] d;
        bit pflip, stop, wr, pe, fe, bk;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic line(input bit which, input bit v);
        if (which) rx_b = v;
        else       rx_a = v;
    endtask

    function automatic bit even_pb(input logic [7:0] d, input bit flip);
        return bit'($countones(d) % 2) ^ flip;
    endfunction

    // Glitch inverts the line for one cycle at the centre of every data bit.
    task automatic send(input bit which, input logic [7:0] d, input bit pb, input bit stop, input bit glitch);
        int div, mid;
        bit q[$];
        div = which ? B_DIV : A_DIV;
        mid = div / 2;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (which) q.push_back(pb);
        q.push_back(stop);
        for (int i = 0; i < q.size(); i++) begin
            line(which, q[i]);
            if (glitch && i >= 1 && i <= 8) begin
                tick(mid); line(which, ~q[i]); tick(1); line(which, q[i]); tick(div - mid - 1);
            end else begin
                tick(div);
            end
        end
        line(which, 1'b1);
    endtask

    task automatic pop_b(input string nm, input logic [7:0] exp);
        chk({nm, "_vld"}, bus_b.rd_valid, 1);
        chk({nm, "_dat"}, bus_b.rd_data, exp);
        bus_b.rd_en = 1'b1; tick(1); bus_b.rd_en = 1'b0;
    endtask

    task automatic clear_b();
        bus_b.clr_err = 1'b1; tick(1); bus_b.clr_err = 1'b0; tick(1);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pe0, fe0, oe0, bk0;
        logic [7:0] q_exp[$];
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
        bus_a.rd_en = 1'b0; bus_a.clr_err = 1'b0;
        bus_b.rd_en = 1'b0; bus_b.clr_err = 1'b0;

        tbl[0] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        tick(3);
        chk("rst_valid", bus_b.rd_valid, 0);
        chk("rst_data", bus_b.rd_data, 0);
        chk("rst_busy", bus_b.rx_busy, 0);
        chk("rst_status", bus_b.err_status, 0);
        chk("rst_full", bus_a.fifo_full, 0);
        rst_n = 1'b1;
        tick(5);

        // Default-rate 8N1: two sync stages plus the stop decision at 9*DIV+MID+1, write visible one cycle later.
        lat = 0;
        fork
            begin send(1'b0, 8'h55, 1'b0, 1'b1, 1'b0); tick(A_DIV); send(1'b0, 8'hA3, 1'b0, 1'b1, 1'b0); end
            begin
                while (!bus_a.rd_valid && lat < 6000) begin tick(1); lat++; end
            end
        join
        chk("a_latency", lat, 2 + (9 * A_DIV + A_MID + 1) + 1);
        chk("a_word0", bus_a.rd_data, 8'h55);
        bus_a.rd_en = 1'b1; tick(1); bus_a.rd_en = 1'b0;
        chk("a_word1", bus_a.rd_data, 8'hA3);
        bus_a.rd_en = 1'b1; tick(1); bus_a.rd_en = 1'b0;
        chk("a_empty", bus_a.rd_valid, 0);
        chk("a_no_err", a_err_n, 0);

        rx_b = 1'b0; tick(6);
        chk("false_busy_hi", bus_b.rx_busy, 1);
        rx_b = 1'b1; tick(3 * B_DIV);
        chk("false_busy_lo", bus_b.rx_busy, 0);
        chk("false_nowrite", bus_b.rd_valid, 0);
        chk("false_nopulse", b_pe + b_fe + b_oe + b_bk, 0);

        for (int i = 0; i < 9; i++) begin
            pe0 = b_pe; fe0 = b_fe; bk0 = b_bk;
            send(1'b1, tbl[i].d, even_pb(tbl[i].d, tbl[i].pflip), tbl[i].stop, 1'b0);
            tick(2 * B_DIV);
            chk($sformatf("vec%0d_pe", i), b_pe - pe0, tbl[i].pe);
            chk($sformatf("vec%0d_fe", i), b_fe - fe0, tbl[i].fe);
            chk($sformatf("vec%0d_bk", i), b_bk - bk0, tbl[i].bk);
            chk($sformatf("vec%0d_status", i), bus_b.err_status, {tbl[i].bk, 1'b0, tbl[i].fe, tbl[i].pe});
            chk($sformatf("vec%0d_valid", i), bus_b.rd_valid, tbl[i].wr);
            if (tbl[i].wr) pop_b($sformatf("vec%0d", i), tbl[i].d);
            clear_b();
        end
        chk("status_cleared", bus_b.err_status, 0);

        bk0 = b_bk; fe0 = b_fe;
        rx_b = 1'b0; tick(22 * B_DIV);
        chk("brk_once", b_bk - bk0, 1);
        chk("brk_no_fe", b_fe - fe0, 0);
        chk("brk_busy", bus_b.rx_busy, 1);
        rx_b = 1'b1; tick(4);
        chk("brk_release", bus_b.rx_busy, 0);
        send(1'b1, 8'h5A, even_pb(8'h5A, 1'b0), 1'b1, 1'b0);
        tick(B_DIV);
        pop_b("after_brk", 8'h5A);
        clear_b();

        oe0 = b_oe;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 8'h10 + 8'(i), even_pb(8'h10 + 8'(i), 1'b0), 1'b1, 1'b0);
            tick(B_DIV);
            if (i == 2) chk("fifo_not_full3", bus_b.fifo_full, 0);
            if (i == 3) chk("fifo_full4", bus_b.fifo_full, 1);
        end
        chk("overrun_once", b_oe - oe0, 1);
        chk("overrun_status", bus_b.err_status[2], 1);
        for (int i = 0; i < 4; i++) pop_b($sformatf("ovr_pop%0d", i), 8'h10 + 8'(i));
        chk("ovr_empty", bus_b.rd_valid, 0);
        clear_b();

        oe0 = b_oe;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 8'h20 + 8'(i), even_pb(8'h20 + 8'(i), 1'b0), 1'b1, 1'b0);
            tick(B_DIV);
        end
        fork
            send(1'b1, 8'h24, even_pb(8'h24, 1'b0), 1'b1, 1'b0);
            begin
                tick(2 + 10 * B_DIV + B_MID + 1);
                chk("same_cycle_head", bus_b.rd_data, 8'h20);
                bus_b.rd_en = 1'b1; tick(1); bus_b.rd_en = 1'b0;
                chk("same_cycle_full", bus_b.fifo_full, 1);
            end
        join
        tick(B_DIV);
        chk("same_cycle_no_ovr", b_oe - oe0, 0);
        for (int i = 1; i < 5; i++) pop_b($sformatf("pp_pop%0d", i), 8'h20 + 8'(i));
        chk("pp_empty", bus_b.rd_valid, 0);

        send(1'b1, 8'hC9, even_pb(8'hC9, 1'b0), 1'b1, 1'b1);
        tick(B_DIV);
        pop_b("glitch0", 8'hC9);
        send(1'b1, 8'h36, even_pb(8'h36, 1'b0), 1'b1, 1'b1);
        tick(B_DIV);
        pop_b("glitch1", 8'h36);

        send(1'b1, 8'h42, even_pb(8'h42, 1'b0), 1'b1, 1'b0);
        send(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        tick(B_DIV);
        rx_b = 1'b0; tick(2 * B_DIV);
        rx_b = 1'b1; tick(3);
        rst_n = 1'b0; tick(2);
        chk("mid_rst_valid", bus_b.rd_valid, 0);
        chk("mid_rst_data", bus_b.rd_data, 0);
        chk("mid_rst_busy", bus_b.rx_busy, 0);
        chk("mid_rst_status", bus_b.err_status, 0);
        rst_n = 1'b1; tick(12 * B_DIV);
        chk("post_rst_idle", bus_b.rx_busy | bus_b.rd_valid, 0);
        send(1'b1, 8'h9E, even_pb(8'h9E, 1'b0), 1'b1, 1'b0);
        tick(B_DIV);
        pop_b("post_rst", 8'h9E);

        // Randomised frames against a frame-level outcome model and a queue standing in for the FIFO.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            bit pb, stop, e_bk, e_pe, e_fe, e_oe;
            int r;
            d = 8'($urandom);
            r = $urandom_range(0, 7);
            pb = even_pb(d, (r == 1) || (r == 3));
            stop = !((r == 2) || (r == 3));
            if (r == 4) begin d = 8'h00; pb = 1'b0; stop = 1'b0; end
            e_bk = (d == 8'h00) && !pb && !stop;
            e_pe = !e_bk && (($countones(d) + int'(pb)) % 2 != 0);
            e_fe = !e_bk && !stop;
            e_oe = 1'b0;
            if (!e_bk && !e_pe && !e_fe) begin
                if (q_exp.size() < 4) q_exp.push_back(d);
                else e_oe = 1'b1;
            end
            pe0 = b_pe; fe0 = b_fe; oe0 = b_oe; bk0 = b_bk;
            send(1'b1, d, pb, stop, 1'b0);
            tick(2 * B_DIV);
            chk($sformatf("rnd%0d_flags", n), {b_bk - bk0, b_oe - oe0, b_fe - fe0, b_pe - pe0},
                {32'(e_bk), 32'(e_oe), 32'(e_fe), 32'(e_pe)});
            chk($sformatf("rnd%0d_valid", n), bus_b.rd_valid, q_exp.size() != 0);
            chk($sformatf("rnd%0d_full", n), bus_b.fifo_full, q_exp.size() == 4);
            if ($urandom_range(0, 1) == 1 && q_exp.size() != 0)
                pop_b($sformatf("rnd%0d_pop", n), q_exp.pop_front());
        end
        while (q_exp.size() != 0) pop_b("rnd_drain", q_exp.pop_front());
        chk("rnd_drained", bus_b.rd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver with a 3-sample majority vote at bit centre, configurable data width, parity and stop bits, false-start rejection, break detection and a show-ahead receive FIFO. Sits between the `rx` pin and the client-side command logic. Errored words are dropped and flagged, never written, so downstream logic only sees clean bytes.

## Interface
- `CLK_FREQ`, 50_000_000, iCLK frequency in Hz
- `BAUD`, 115200, line rate; bit period `DIV = CLK_FREQ/BAUD` (integer truncation, 434 at defaults), `MID = DIV/2` (217)
- `DATA_BITS`, 8, data bits per frame, legal 5..9, LSB first
- `PARITY`, 0, 0 none / 1 odd / 2 even
- `STOP_BITS`, 1, 1 or 2
- `FIFO_DEPTH`, 4, receive FIFO entries, power of two ≥2
- `iCLK`  in  1  system clock
- `RST_n`  in  1  asynchronous, active-low reset
- `rx`  in  1  serial line, idle high, asynchronous to iCLK
- `rd_en`  in  1  pop request; ignored when `rd_valid`=0
- `clr_err`  in  1  clears `err_status`
- `rd_data`  out  DATA_BITS  FIFO head word, valid while `rd_valid`=1
- `rd_valid`  out  1  FIFO not empty
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH words
- `rx_busy`  out  1  receiver not in IDLE
- `parity_err`, `frame_err`, `overrun_err`, `break_det`  out  1 each  one-cycle pulses
- `err_status`  out  4  sticky {break, overrun, frame, parity}

## Operation
- `rx` passes two-flop synchroniser -> `rx_s`; `rx_d` = `rx_s` delayed one cycle. Start edge = `rx_d`=1 & `rx_s`=0, honoured only in IDLE.
- Bit counter `cnt` (0..DIV-1) clears to 0 on the start-edge cycle, wraps DIV-1 -> 0 advancing bit index. Samples taken at cnt = MID-1, MID, MID+1; majority decided at cnt = MID+1.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY≠0) -> STOP -> IDLE; BRK_WAIT additionally.
- START: majority 1 -> false start, back to IDLE, nothing flagged.
- DATA: shift majority into bit index 0..DATA_BITS-1; after last -> PARITY or STOP.
- PARITY: odd requires XOR(data, p)=1, even requires 0; mismatch latched as parity fault.
- STOP: each stop bit sampled; STOP_BITS=2 checks both. At decision of final stop bit:
  - break: all data bits 0, parity bit 0 (if present), stop sample 0 -> `break_det`, no write, -> BRK_WAIT.
  - stop sample 0 (not break) -> `frame_err`, no write, -> IDLE.
  - parity fault -> `parity_err`, no write, -> IDLE.
  - clean, FIFO not full (or popped same cycle) -> write; FIFO full with no pop -> drop, `overrun_err`.
  - frame and parity faults simultaneously: both pulse.
- BRK_WAIT: -> IDLE once `rx_s`=1.
- IDLE entered at centre of stop bit, so a start edge in the second half of the stop bit is accepted.
- FIFO: show-ahead, `rd_data` = head. Pop on `rd_en`&`rd_valid`. Simultaneous push and pop legal in any fill, including full (count unchanged).
- `err_status[i]` set by its pulse, cleared by `clr_err`; set wins over same-cycle clear.

## Timing
- Reset: all outputs 0, `rd_data` 0, state IDLE, FIFO empty, `cnt` 0.
- Pin to edge detect: 3 iCLK (2 sync + 1 edge compare).
- Frame bit k (start = 0) decided k·DIV+MID+1 cycles after start-edge cycle; defaults, 8N1: stop decided at 9·434+218 = 4124.
- Write at stop decision cycle; `rd_valid` rises next cycle; error pulses in stop-decision cycle +1, `err_status` same cycle.
- Pop: head advances next cycle; `rd_valid` falls next cycle when last word popped.
- `rx_busy` high from cycle after start edge through cycle of IDLE re-entry.
- `RST_n` low mid-frame: immediate return to reset state, partial word discarded, FIFO flushed.

## Test plan
- Defaults, send 0x55 then 0xA3 8N1 at 115200 -> `rd_valid` 4125 cycles after first edge, `rd_data` 0x55, pop, then 0xA3; no error pulses.
- 0.4-bit low glitch on idle `rx` -> false start, `rx_busy` returns 0, no write, no pulse.
- PARITY=2, send 0x07 with parity bit 0 -> `parity_err` pulse, `err_status`=4'b0001, FIFO empty; then correct frame (parity 1) -> 0x07 received.
- Frame 0x3C with stop bit 0 -> `frame_err`, no write; 0x00 with stop 0, line held low 2 frames -> `break_det` once, `rx_busy` until line high, next 0x5A received.
- FIFO_DEPTH=4, send 5 words without `rd_en` -> `fifo_full` after 4th, `overrun_err` on 5th, pop yields first 4 in order; repeat with `rd_en` on 5th write cycle -> all 5 received.
- Single-cycle glitches on centre sample of each data bit -> majority recovers exact word; `RST_n` pulse mid-frame -> all outputs 0, FIFO empty, next frame received correctly.
